// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - PC, imem request/response and decode handshake bundle for the fetch stage
interface if_fetch_unit_if #(
    parameter int BW = 32,
    parameter int IW = 32
);
    logic [BW-1:0] pc_in;
    logic          pc_stall;
    logic          flush;
    logic          imem_req_valid;
    logic [BW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_data;
    logic          id_valid;
    logic [BW-1:0] id_pc;
    logic [IW-1:0] id_instr;
    logic          id_ready;

    modport master (
        input  pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
        output pc_stall, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );

    modport slave (
        output pc_in, flush, imem_req_ready, imem_resp_valid, imem_resp_data, id_ready,
        input  pc_stall, imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr
    );
endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: tagged imem requests, in-order response queue, flush drop
module if_fetch_unit #(
    parameter int BW    = 32,
    parameter int IW    = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    if_fetch_unit_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [BW-1:0]    pc_q    [DEPTH];
    logic [IW-1:0]    instr_q [DEPTH];
    logic [DEPTH-1:0] filled_q, filled_d;
    ptr_t             alloc_ptr_q, alloc_ptr_d;
    ptr_t             fill_ptr_q, fill_ptr_d;
    ptr_t             rd_ptr_q, rd_ptr_d;
    cnt_t             used_q, used_d;
    cnt_t             drop_cnt_q, drop_cnt_d;
    cnt_t             outst_q, outst_d;

    cnt_t credits;
    cnt_t pending;
    logic accept;
    logic pop;
    logic fill;
    logic drop;

    // Entries already owed to flushed fetches still occupy a credit until their response drains.
    assign credits = cnt_t'(DEPTH) - used_q - drop_cnt_q;
    assign pending = drop_cnt_q + outst_q;

    assign bus.imem_req_valid = !rst && !bus.flush && (credits != '0);
    assign bus.imem_req_addr  = bus.pc_in;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign bus.pc_stall       = !accept;

    assign bus.id_valid = !rst && !bus.flush && filled_q[rd_ptr_q];
    assign bus.id_pc    = pc_q[rd_ptr_q];
    assign bus.id_instr = instr_q[rd_ptr_q];
    assign pop          = bus.id_valid && bus.id_ready;

    assign drop = bus.imem_resp_valid && (drop_cnt_q != '0);
    assign fill = bus.imem_resp_valid && (drop_cnt_q == '0) && (outst_q != '0) && !bus.flush;

    always_comb begin
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        used_d      = used_q;
        outst_d     = outst_q;
        drop_cnt_d  = drop_cnt_q;
        if (bus.flush) begin
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            used_d      = '0;
            outst_d     = '0;
            drop_cnt_d  = (bus.imem_resp_valid && pending != '0) ? pending - cnt_t'(1) : pending;
        end else begin
            if (accept) begin
                filled_d[alloc_ptr_q] = 1'b0;
                alloc_ptr_d           = alloc_ptr_q + ptr_t'(1);
            end
            if (fill) begin
                filled_d[fill_ptr_q] = 1'b1;
                fill_ptr_d           = fill_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                filled_d[rd_ptr_q] = 1'b0;
                rd_ptr_d           = rd_ptr_q + ptr_t'(1);
            end
            used_d     = used_q + cnt_t'(accept) - cnt_t'(pop);
            outst_d    = outst_q + cnt_t'(accept) - cnt_t'(fill);
            drop_cnt_d = drop_cnt_q - cnt_t'(drop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            used_q      <= '0;
            outst_q     <= '0;
            drop_cnt_q  <= '0;
        end else begin
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            used_q      <= used_d;
            outst_q     <= outst_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[alloc_ptr_q] <= bus.pc_in;
        end
        if (fill) begin
            instr_q[fill_ptr_q] <= bus.imem_resp_data;
        end
    end

    // A response with nothing outstanding and nothing to drop means the memory broke ordering.
    resp_protocol_a: assert property (@(posedge clk) disable iff (rst)
        !(bus.imem_resp_valid && drop_cnt_q == '0 && outst_q == '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit with PC register and imem models
module tb_if_fetch_unit;
    localparam int BW    = 32;
    localparam int IW    = 32;
    localparam int DEPTH = 4;

    typedef struct {
        logic [BW-1:0] addr;
        int            due;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if #(.BW(BW), .IW(IW)) bus ();

    if_fetch_unit #(.BW(BW), .IW(IW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            lat = 1;
    int            acc_total = 0;
    int            pop_base = 0;
    int            a0 = 0;
    logic [BW-1:0] redir = 32'h100;
    req_t          mq[$];
    logic [BW+IW-1:0] popq[$];

    function automatic logic [IW-1:0] mk_instr(input logic [BW-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // Instruction memory: in-order, fixed latency set by lat, one response per cycle
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            mq.delete();
            bus.imem_resp_valid <= 1'b0;
            bus.imem_resp_data  <= '0;
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready)
                mq.push_back('{bus.imem_req_addr, cyc + lat - 1});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_resp_valid <= 1'b1;
                bus.imem_resp_data  <= mk_instr(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_resp_valid <= 1'b0;
            end
        end
    end

    // PC register: redirect on flush, advance only on accepted fetch
    always @(posedge clk) begin
        if (rst)
            bus.pc_in <= '0;
        else if (bus.flush)
            bus.pc_in <= redir;
        else if (!bus.pc_stall)
            bus.pc_in <= bus.pc_in + 32'd4;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (bus.id_valid && bus.id_ready)
                popq.push_back({bus.id_pc, bus.id_instr});
            if (bus.imem_req_valid && bus.imem_req_ready)
                acc_total <= acc_total + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input int idx, input logic [BW-1:0] pc);
        chk({tag, "_present"}, 64'(popq.size() > idx), 64'd1);
        if (popq.size() > idx) begin
            chk({tag, "_pc"}, 64'(popq[idx][BW+IW-1:IW]), 64'(pc));
            chk({tag, "_instr"}, 64'(popq[idx][IW-1:0]), 64'(mk_instr(pc)));
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        bus.flush          = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.id_ready       = 1'b0;

        // Reset held for two cycles
        @(negedge clk); #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("rst_pc_stall", 64'(bus.pc_stall), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        #1;
        chk("post_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("post_rst_req_addr", 64'(bus.imem_req_addr), 64'h0);
        chk("post_rst_pc_stall", 64'(bus.pc_stall), 64'd0);

        // Streaming with 1-cycle memory: one decode entry per cycle, wrapping the queue
        @(negedge clk);
        chk("t2_latency_id_valid", 64'(bus.id_valid), 64'd0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t2_id_valid", 64'(bus.id_valid), 64'd1);
            chk("t2_id_pc", 64'(bus.id_pc), 64'(32'(4 * i)));
            chk("t2_id_instr", 64'(bus.id_instr), 64'(mk_instr(32'(4 * i))));
            chk("t2_req_valid", 64'(bus.imem_req_valid), 64'd1);
        end
        bus.imem_req_ready = 1'b0;
        tick(6);
        chk("t2_total_pops", 64'(popq.size()), 64'd7);
        chk_pop("t2_last", 6, 32'h18);
        pop_base = popq.size();

        // Backpressure: exactly DEPTH accepts, then stall; drain in order and resume
        bus.id_ready       = 1'b0;
        bus.imem_req_ready = 1'b1;
        a0 = acc_total;
        tick(8);
        chk("t3_accepts", 64'(acc_total - a0), 64'd4);
        chk("t3_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t3_pc_stall", 64'(bus.pc_stall), 64'd1);
        chk("t3_head_valid", 64'(bus.id_valid), 64'd1);
        chk("t3_head_pc", 64'(bus.id_pc), 64'h1C);
        bus.id_ready = 1'b1;
        tick(8);
        chk_pop("t3_e0", pop_base, 32'h1C);
        chk_pop("t3_e1", pop_base + 1, 32'h20);
        chk_pop("t3_e2", pop_base + 2, 32'h24);
        chk_pop("t3_e3", pop_base + 3, 32'h28);
        chk_pop("t3_resume", pop_base + 4, 32'h2C);
        bus.imem_req_ready = 1'b0;
        tick(10);
        pop_base = popq.size();

        // Flush with three fetches in flight on a 5-cycle memory
        lat = 5;
        bus.imem_req_ready = 1'b1;
        a0 = acc_total;
        tick(3);
        chk("t4_inflight", 64'(acc_total - a0), 64'd3);
        bus.flush = 1'b1;
        #1;
        chk("t4_flush_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t4_flush_pc_stall", 64'(bus.pc_stall), 64'd1);
        chk("t4_flush_id_valid", 64'(bus.id_valid), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        for (int k = 0; k < 40 && popq.size() <= pop_base + 1; k++) @(negedge clk);
        chk_pop("t4_first", pop_base, 32'h100);
        chk_pop("t4_second", pop_base + 1, 32'h104);
        bus.imem_req_ready = 1'b0;
        tick(20);
        lat = 1;
        pop_base = popq.size();

        // Reset mid-stream with entries queued
        bus.id_ready       = 1'b0;
        bus.imem_req_ready = 1'b1;
        tick(3);
        chk("t6_pre_id_valid", 64'(bus.id_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t6_rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("t6_rst_pc_stall", 64'(bus.pc_stall), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        a0 = acc_total;
        #1;
        chk("t6_post_id_valid", 64'(bus.id_valid), 64'd0);
        chk("t6_post_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("t6_post_req_addr", 64'(bus.imem_req_addr), 64'h0);
        tick(6);
        chk("t6_full_credits", 64'(acc_total - a0), 64'd4);
        chk("t6_full_req_valid", 64'(bus.imem_req_valid), 64'd0);
        bus.id_ready = 1'b1;
        tick(3);
        chk_pop("t6_first", pop_base, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
